// File: rtl/apb3_completer_mem.sv
`default_nettype none
// ============================================================================
// Module      : apb3_completer_mem
// Description : APB3 completer over a word-addressed memory with programmable
//               wait states, PSLVERR on out-of-range access, transfer counters.
// Revision    : 1.0 - initial release
// ============================================================================
module apb3_completer_mem #(
    parameter int ADDRESS_WIDTH = 20,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_DEPTH     = 256,
    parameter int WAIT_STATES   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] paddr,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [DATA_WIDTH-1:0]    pwdata,
    output logic [DATA_WIDTH-1:0]    prdata,
    output logic                     pready,
    output logic                     pslverr,
    output logic [31:0]              count_writes,
    output logic [31:0]              count_reads,
    output logic [31:0]              count_errors,
    output logic                     protocol_error
);

    localparam int                   c_idx_w     = $clog2(MEM_DEPTH);
    localparam logic [ADDRESS_WIDTH:0] c_mem_bytes = (ADDRESS_WIDTH+1)'(MEM_DEPTH * 4);
    localparam logic [3:0]           c_wait      = 4'(WAIT_STATES);

    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_access = 1'b1;

    logic [0:0]            r_state;
    logic [3:0]            r_wait_cnt;
    logic                  r_write;
    logic                  r_oor;
    logic [c_idx_w-1:0]    r_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic [31:0]           r_count_writes;
    logic [31:0]           r_count_reads;
    logic [31:0]           r_count_errors;
    logic                  r_protocol_error;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  w_oor;
    logic [c_idx_w-1:0]    w_idx;
    logic                  w_pready;
    logic                  w_complete;

    function automatic logic [31:0] f_sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign w_oor      = ({1'b0, paddr} >= c_mem_bytes);
    assign w_idx      = paddr[2 +: c_idx_w];
    // Decoded from registers only, so no APB input reaches pready combinationally.
    assign w_pready   = (r_state == c_st_access) && (r_wait_cnt == c_wait);
    assign w_complete = w_pready && psel && penable;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= c_st_idle;
            r_wait_cnt       <= 4'd0;
            r_write          <= 1'b0;
            r_oor            <= 1'b0;
            r_idx            <= '0;
            r_wdata          <= '0;
            r_prdata         <= '0;
            r_count_writes   <= 32'd0;
            r_count_reads    <= 32'd0;
            r_count_errors   <= 32'd0;
            r_protocol_error <= 1'b0;
        end else if (r_state == c_st_idle) begin
            if (psel && !penable) begin
                r_state    <= c_st_access;
                r_wait_cnt <= 4'd0;
                r_write    <= pwrite;
                r_oor      <= w_oor;
                r_idx      <= w_idx;
                r_wdata    <= pwdata;
                if (!pwrite) begin
                    r_prdata <= w_oor ? '0 : r_mem[w_idx];
                end
            end else if (psel && penable) begin
                r_protocol_error <= 1'b1;
            end
        end else begin
            if (!psel) begin
                r_state          <= c_st_idle;
                r_protocol_error <= 1'b1;
            end else if (w_complete) begin
                r_state <= c_st_idle;
                if (r_oor) begin
                    r_count_errors <= f_sat_inc(r_count_errors);
                end else if (r_write) begin
                    r_count_writes <= f_sat_inc(r_count_writes);
                end else begin
                    r_count_reads <= f_sat_inc(r_count_reads);
                end
            end else if (r_wait_cnt < c_wait) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end
    end

    // Storage is deliberately not reset; reset only suppresses an in-flight write.
    always_ff @(posedge clk) begin
        if (!reset && (r_state == c_st_access) && w_complete && r_write && !r_oor) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign prdata         = r_prdata;
    assign pready         = w_pready;
    assign pslverr        = w_pready && r_oor;
    assign count_writes   = r_count_writes;
    assign count_reads    = r_count_reads;
    assign count_errors   = r_count_errors;
    assign protocol_error = r_protocol_error;

endmodule
`default_nettype wire

// File: tb/tb_apb3_completer_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb3_completer_mem
// Description : Self-checking bench; two completers (0 and 3 wait states)
//               compared every cycle against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb3_completer_mem;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0][19:0] paddr = '0;
    logic [1:0]       psel = '0;
    logic [1:0]       penable = '0;
    logic [1:0]       pwrite = '0;
    logic [1:0][31:0] pwdata = '0;
    logic [1:0][31:0] prdata;
    logic [1:0]       pready;
    logic [1:0]       pslverr;
    logic [1:0][31:0] count_writes;
    logic [1:0][31:0] count_reads;
    logic [1:0][31:0] count_errors;
    logic [1:0]       protocol_error;

    // Instance 0 has no wait states, instance 1 has three.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        apb3_completer_mem #(
            .ADDRESS_WIDTH(20), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(g * 3)
        ) u_dut (
            .clk(clk), .reset(reset), .paddr(paddr[g]), .psel(psel[g]),
            .penable(penable[g]), .pwrite(pwrite[g]), .pwdata(pwdata[g]),
            .prdata(prdata[g]), .pready(pready[g]), .pslverr(pslverr[g]),
            .count_writes(count_writes[g]), .count_reads(count_reads[g]),
            .count_errors(count_errors[g]), .protocol_error(protocol_error[g])
        );
    end

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    logic [1:0]       e_pready  = '0;
    logic [1:0]       e_pslverr = '0;
    logic [1:0][31:0] e_prdata  = '0;
    logic [1:0]       e_pk      = 2'b11;
    logic [1:0][31:0] e_cw      = '0;
    logic [1:0][31:0] e_cr      = '0;
    logic [1:0][31:0] e_ce      = '0;
    logic [1:0]       e_perr    = '0;
    logic [31:0]      m_mem [2][256];
    bit               m_val [2][256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int w = 0; w < 2; w++) begin
                check($sformatf("pready[%0d]", w), {31'b0, pready[w]}, {31'b0, e_pready[w]});
                check($sformatf("pslverr[%0d]", w), {31'b0, pslverr[w]}, {31'b0, e_pslverr[w]});
                check($sformatf("perr[%0d]", w), {31'b0, protocol_error[w]}, {31'b0, e_perr[w]});
                check($sformatf("count_writes[%0d]", w), count_writes[w], e_cw[w]);
                check($sformatf("count_reads[%0d]", w), count_reads[w], e_cr[w]);
                check($sformatf("count_errors[%0d]", w), count_errors[w], e_ce[w]);
                if (e_pk[w]) check($sformatf("prdata[%0d]", w), prdata[w], e_prdata[w]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        psel    = '0;
        penable = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        @(negedge clk);
        check(name, act, exp);
        #1;
    endtask

    // One complete transfer; leaves the bus ready for a back-to-back setup.
    task automatic xfer(input int w, input bit wr, input logic [19:0] a, input logic [31:0] d);
        int ws;
        int idx;
        bit oor;
        ws  = w * 3;
        idx = int'(a[9:2]);
        oor = (a >= 20'h400);
        paddr[w] = a; pwdata[w] = d; pwrite[w] = wr; psel[w] = 1'b1; penable[w] = 1'b0;
        step();
        if (!wr) begin
            if (oor) begin
                e_prdata[w] = 32'd0; e_pk[w] = 1'b1;
            end else begin
                e_prdata[w] = m_mem[w][idx]; e_pk[w] = m_val[w][idx];
            end
        end
        penable[w] = 1'b1;
        for (int i = 0; i <= ws; i++) begin
            e_pready[w]  = (i == ws);
            e_pslverr[w] = (i == ws) && oor;
            paddr[w]  = 20'($urandom);
            pwdata[w] = $urandom;
            step();
        end
        e_pready[w] = 1'b0; e_pslverr[w] = 1'b0;
        if (oor) e_ce[w] = e_ce[w] + 1;
        else if (wr) begin
            e_cw[w] = e_cw[w] + 1; m_mem[w][idx] = d; m_val[w][idx] = 1'b1;
        end else e_cr[w] = e_cr[w] + 1;
        psel[w] = 1'b0; penable[w] = 1'b0;
    endtask

    task automatic no_setup(input int w);
        psel[w] = 1'b1; penable[w] = 1'b1;
        step();
        e_perr[w] = 1'b1;
        step();
        idle(1);
    endtask

    task automatic abort_write(input logic [19:0] a, input logic [31:0] d);
        paddr[1] = a; pwdata[1] = d; pwrite[1] = 1'b1; psel[1] = 1'b1; penable[1] = 1'b0;
        step();
        penable[1] = 1'b1;
        step();
        psel[1] = 1'b0; penable[1] = 1'b0;
        step();
        e_perr[1] = 1'b1;
    endtask

    task automatic reset_mid_write(input logic [19:0] a, input logic [31:0] d);
        paddr[1] = a; pwdata[1] = d; pwrite[1] = 1'b1; psel[1] = 1'b1; penable[1] = 1'b0;
        step();
        penable[1] = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        e_prdata = '0; e_pk = 2'b11; e_cw = '0; e_cr = '0; e_ce = '0; e_perr = '0;
        reset = 1'b0; psel = '0; penable = '0;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] a;
        int w;
        for (int i = 0; i < 256; i++) begin
            m_val[0][i] = 1'b0; m_val[1][i] = 1'b0;
            m_mem[0][i] = '0;   m_mem[1][i] = '0;
        end
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        step();
        lit("rst_count_writes0", count_writes[0], 32'd0);
        lit("rst_prdata1", prdata[1], 32'd0);

        xfer(0, 1'b1, 20'h400, 32'h1234_5678);
        xfer(0, 1'b0, 20'h400, 32'h0);
        idle(1);
        lit("oor_count_errors", count_errors[0], 32'd2);
        lit("oor_count_writes", count_writes[0], 32'd0);
        lit("oor_count_reads", count_reads[0], 32'd0);
        lit("oor_prdata", prdata[0], 32'd0);

        xfer(0, 1'b1, 20'h000, 32'h1111_2222);
        xfer(0, 1'b1, 20'h400, 32'h3333_4444);
        xfer(0, 1'b0, 20'h003, 32'h0);
        idle(1);
        lit("oor_word0_intact", prdata[0], 32'h1111_2222);

        xfer(0, 1'b1, 20'h010, 32'hDEAD_BEEF);
        xfer(0, 1'b0, 20'h010, 32'h0);
        idle(1);
        lit("ws0_prdata", prdata[0], 32'hDEAD_BEEF);
        lit("ws0_count_writes", count_writes[0], 32'd2);
        lit("ws0_count_reads", count_reads[0], 32'd2);

        for (int i = 0; i < 8; i++) xfer(0, 1'b1, 20'(i * 4), 32'hA500_0000 + 32'(i));
        for (int i = 0; i < 8; i++) xfer(0, 1'b0, 20'(i * 4), 32'h0);
        idle(1);
        lit("b2b_last_prdata", prdata[0], 32'hA500_0007);
        lit("b2b_count_writes", count_writes[0], 32'd10);
        lit("b2b_count_reads", count_reads[0], 32'd10);

        xfer(1, 1'b1, 20'h020, 32'hCAFE_F00D);
        xfer(1, 1'b0, 20'h020, 32'h0);
        idle(2);
        lit("ws3_prdata", prdata[1], 32'hCAFE_F00D);

        no_setup(0);
        lit("no_setup_perr", {31'b0, protocol_error[0]}, 32'd1);

        xfer(1, 1'b1, 20'h040, 32'h0123_4567);
        abort_write(20'h040, 32'h89AB_CDEF);
        idle(1);
        lit("abort_perr", {31'b0, protocol_error[1]}, 32'd1);
        lit("abort_count_writes", count_writes[1], 32'd2);
        xfer(1, 1'b0, 20'h040, 32'h0);
        idle(1);
        lit("abort_word_intact", prdata[1], 32'h0123_4567);

        reset_mid_write(20'h020, 32'hFFFF_0000);
        lit("rstmid_count_reads", count_reads[1], 32'd0);
        lit("rstmid_perr", {31'b0, protocol_error[1]}, 32'd0);
        xfer(1, 1'b0, 20'h020, 32'h0);
        idle(1);
        lit("rstmid_word_intact", prdata[1], 32'hCAFE_F00D);
        xfer(1, 1'b1, 20'h020, 32'h5555_AAAA);
        xfer(1, 1'b0, 20'h020, 32'h0);
        idle(1);
        lit("rstmid_new_xfer", prdata[1], 32'h5555_AAAA);

        for (int n = 0; n < 300; n++) begin
            w = int'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'($urandom_range(0, 127));
            xfer(w, 1'($urandom), a, $urandom);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb3_completer_mem.md
# apb3_completer_mem

Synthesizable APB3 completer backed by a word-addressed memory. It is the responder end for the APB3 requester and its transfer-counter stimulus. It answers writes and reads with a configurable number of wait states and flags out-of-range accesses with PSLVERR. It also exposes completed-transfer counters, so a bench or Renode co-simulation can cross-check them against the requester's write/read counts.

## Interface
- AddressWidth, 20, PADDR width in bits (byte address)
- DataWidth, 32, PWDATA/PRDATA width; only 32 is supported
- MemDepth, 256, number of 32-bit words; power of two, at least 2
- WaitStates, 0, access-phase cycles with PREADY low before completion (0..15)
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- paddr  input  AddressWidth  byte address
- psel  input  1  select
- penable  input  1  enable (access phase)
- pwrite  input  1  1 = write, 0 = read
- pwdata  input  DataWidth  write data
- prdata  output  DataWidth  read data
- pready  output  1  transfer completes on an edge where psel & penable & pready
- pslverr  output  1  error response; qualified by pready
- count_writes  output  32  completed non-error writes
- count_reads  output  32  completed non-error reads
- count_errors  output  32  completed transfers with pslverr
- protocol_error  output  1  sticky; set on a requester protocol violation

## Operation
- FSM states: IDLE, ACCESS.
  - IDLE to ACCESS: psel=1 and penable=0 (setup phase). On this edge, register paddr, pwrite, pwdata and the range check, and load wait_cnt with 0.
  - ACCESS to IDLE: completion, i.e. psel & penable & pready. Back-to-back transfers re-enter setup from IDLE on the next cycle.
  - ACCESS with psel=0 (requester abort): go to IDLE, set protocol_error, no memory update, no count.
  - In IDLE, psel=1 and penable=1 (access without setup): stay in IDLE, set protocol_error, pready stays 0.
- Address decode:
  - word index = paddr[2 +: log2(MemDepth)].
  - Out of range when paddr >= MemDepth*4.
  - paddr[1:0] is ignored; unaligned addresses round down.
- Write, in range: the memory word is updated on the completion edge and count_writes increments.
- Read, in range: prdata is loaded from memory on the setup edge and is valid while pready=1. It holds its value until the next read setup edge.
- Out of range, on the completion edge:
  - Asserted with pready: pslverr=1.
  - Write: suppressed.
  - Read: prdata=0.
  - Counters: count_errors increments; count_writes and count_reads do not.
- Counters saturate at 2^32-1.
- protocol_error clears only on reset.
- Memory contents are not reset. A read before any write returns an undefined value; the bench must not check it.

## Timing
- Reset values:
  - FSM: IDLE.
  - pready=0, pslverr=0, prdata=0.
  - All counters 0; protocol_error=0.
- pready = (state==ACCESS) && (wait_cnt==WaitStates). It is decoded from registers only, with no combinational path from APB inputs.
- wait_cnt increments each ACCESS cycle while below WaitStates.
- Transfer length, setup through completion:
  - 2 cycles with WaitStates=0.
  - 2+WaitStates cycles in general.
- pslverr = pready && registered out-of-range flag.
- Counters and memory update on the completion edge; the new value is visible the following cycle.
- During wait states, pwdata and paddr changes are ignored, because values are captured at setup.
- Reset asserted mid-ACCESS:
  - Next cycle is IDLE with pready=0.
  - The in-flight write is dropped and not counted.

## Test plan
- WaitStates=0: write 0xDEADBEEF to 0x10, then read 0x10. Each transfer is 2 cycles and pready is high in the first access cycle. prdata=0xDEADBEEF, pslverr=0, count_writes=1, count_reads=1.
- WaitStates=3: single write. pready is low for 3 access cycles, then high. The transfer takes 5 cycles and the memory is updated only on the completion edge.
- Out-of-range: with MemDepth=256, write, then read, at 0x400. pslverr=1 with pready on both. The read returns prdata=0. count_errors=2, other counters 0, and word 0 is unchanged.
- Back-to-back: 8 writes to 0x0..0x1C, then 8 reads, with no idle cycles. Read data matches the written data, count_writes=8, count_reads=8.
- Protocol violations:
  - psel+penable asserted without a setup phase: protocol_error=1 and no pready.
  - psel dropped during wait states: FSM returns to IDLE, no write, counters unchanged.
- Reset mid-access during a write wait state: all outputs return to reset values next cycle, the target word is unchanged, and a new transfer then completes normally.
